keypad_scan_4x4: RTL and testbench

Scans a 4x4 matrix keypad and produces one debounced hex key code per press. It is the input-side counterpart of the button-counter / seven-segment display path: it drives the keypad columns, reads the rows, rejects bounce and multi-key chords, and emits a single-cycle `key_valid` strobe with a 4-bit code. Downstream logic consumes that code directly, for example as the `din` of the hex-to-segment display logic.

---
 rtl/keypad_scan_4x4_if.sv | 13 +
 rtl/keypad_scan_4x4.sv | 159 +++++++++++++++
 tb/tb_keypad_scan_4x4.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_4x4_if.sv
// Keypad scanner bus: row sense lines in, column drive and debounced key report out.
// The master side is the scanner; the slave side is the keypad/consumer.
interface keypad_scan_4x4_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       multi_key;

    modport master (input row, output col, key_code, key_valid, key_down, multi_key);
    modport slave  (output row, input col, key_code, key_valid, key_down, multi_key);
endinterface

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: column scan, per-frame classification, frame-level
// debounce and a press/hold/block FSM that emits one key_valid strobe per press.
module keypad_scan_4x4 #(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_FRAMES = 8
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scan_4x4_if.master kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEB_FRAMES + 1);

    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_e;
    typedef enum logic [1:0] {IDLE, HELD, BLOCK} state_e;

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx, col_idx_n;
    logic [3:0]    col_q;
    logic          sample, frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= kp.row;
            row_s2 <= row_s1;
        end
    end

    assign sample    = (dwell == DW'(SCAN_DIV - 1));
    assign frame_end = sample && (col_idx == 2'd3);
    assign col_idx_n = sample ? col_idx + 2'd1 : col_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell   <= '0;
            col_idx <= 2'd0;
            col_q   <= 4'b1110;
        end else begin
            dwell   <= sample ? '0 : dwell + 1'b1;
            col_idx <= col_idx_n;
            col_q   <= ~(4'b0001 << col_idx_n);
        end
    end

    // Intersection count saturates at 2: anything beyond one key is a chord.
    logic [2:0] hits, sum;
    logic [1:0] hit_row, acc_cnt, tot;
    logic [3:0] acc_code, cur_code;
    res_e       frame_res;

    always_comb begin
        hits    = '0;
        hit_row = '0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2[r]) begin
                hits    = hits + 3'd1;
                hit_row = 2'(r);
            end
        end
        sum      = {1'b0, acc_cnt} + hits;
        tot      = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        cur_code = (acc_cnt == 2'd0) ? {hit_row, col_idx} : acc_code;
        case (tot)
            2'd0:    frame_res = RES_NONE;
            2'd1:    frame_res = RES_SINGLE;
            default: frame_res = RES_MULTI;
        endcase
    end

    res_e          prev_res;
    logic [3:0]    prev_code;
    logic [CW-1:0] stable_cnt, cnt_n;
    logic          same, stable;

    assign same   = (frame_res == prev_res) &&
                    ((frame_res != RES_SINGLE) || (cur_code == prev_code));
    assign cnt_n  = !same ? CW'(1) :
                    (stable_cnt >= CW'(DEB_FRAMES)) ? stable_cnt : stable_cnt + 1'b1;
    assign stable = frame_end && (cnt_n == CW'(DEB_FRAMES));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt    <= 2'd0;
            acc_code   <= 4'd0;
            prev_res   <= RES_NONE;
            prev_code  <= 4'd0;
            stable_cnt <= '0;
        end else if (sample) begin
            acc_cnt  <= frame_end ? 2'd0 : tot;
            acc_code <= cur_code;
            if (frame_end) begin
                prev_res   <= frame_res;
                prev_code  <= cur_code;
                stable_cnt <= cnt_n;
            end
        end
    end

    state_e     state, state_n;
    logic [3:0] key_code_q, code_n;
    logic       valid_n, key_valid_q, key_down_q, multi_key_q;

    always_comb begin
        state_n = state;
        code_n  = key_code_q;
        valid_n = 1'b0;
        if (stable) begin
            case (state)
                IDLE: begin
                    if (frame_res == RES_SINGLE) begin
                        code_n  = cur_code;
                        valid_n = 1'b1;
                        state_n = HELD;
                    end else if (frame_res == RES_MULTI) begin
                        state_n = BLOCK;
                    end
                end
                HELD: begin
                    // A different single key while held is a rollover: block it.
                    if (frame_res == RES_NONE)
                        state_n = IDLE;
                    else if (frame_res == RES_MULTI || cur_code != key_code_q)
                        state_n = BLOCK;
                end
                BLOCK: begin
                    if (frame_res == RES_NONE)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            multi_key_q <= 1'b0;
        end else begin
            state       <= state_n;
            key_code_q  <= code_n;
            key_valid_q <= valid_n;
            key_down_q  <= (state_n == HELD);
            multi_key_q <= (state_n == BLOCK);
        end
    end

    assign kp.col       = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;
    assign kp.multi_key = multi_key_q;
endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: directed scenarios plus random key activity, every
// cycle compared against a frame-level behavioural model of the scanner.
module tb_keypad_scan_4x4;
    localparam int SCAN_DIV   = 4;
    localparam int DEB_FRAMES = 3;
    localparam int FRAME      = 4 * SCAN_DIV;
    localparam int M_IDLE = 0, M_HELD = 1, M_BLOCK = 2;
    localparam int R_NONE = -1, R_MULTI = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = '0;
    int          errors = 0, checks = 0, strobes = 0;

    keypad_scan_4x4_if kif ();

    keypad_scan_4x4 #(.SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB_FRAMES)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        kif.row = 4'hF;
        for (int k = 0; k < 16; k++)
            if (pressed[k] && !kif.col[k % 4]) kif.row[k / 4] = 1'b0;
    end

    // Behavioural model state
    int          t = 0;
    int          m_state = M_IDLE;
    logic [3:0]  m_s1 = 4'hF, m_s2 = 4'hF;
    logic [15:0] fmask = '0;
    int          hist[$];
    logic [3:0]  e_code = '0;
    logic        e_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, act, exp, t);
        end
    endtask

    // Advance the model over one clock edge using the inputs about to be sampled.
    task automatic model_edge();
        int         cidx, res, n;
        logic [3:0] rin;
        logic       stable;
        cidx = (t / SCAN_DIV) % 4;
        rin  = 4'hF;
        for (int k = 0; k < 16; k++)
            if (pressed[k] && (k % 4) == cidx) rin[k / 4] = 1'b0;
        if (rst) begin
            t = 0; m_s1 = 4'hF; m_s2 = 4'hF; fmask = '0; hist.delete();
            m_state = M_IDLE; e_code = '0; e_valid = 1'b0;
            return;
        end
        e_valid = 1'b0;
        if (t % SCAN_DIV == SCAN_DIV - 1) begin
            for (int r = 0; r < 4; r++)
                if (!m_s2[r]) fmask[r * 4 + cidx] = 1'b1;
            if (cidx == 3) begin
                n = 0; res = R_NONE;
                for (int k = 0; k < 16; k++)
                    if (fmask[k]) begin n++; res = k; end
                if (n > 1) res = R_MULTI;
                hist.push_back(res);
                if (hist.size() > DEB_FRAMES) void'(hist.pop_front());
                stable = (hist.size() == DEB_FRAMES);
                foreach (hist[i]) if (hist[i] != res) stable = 1'b0;
                if (stable) begin
                    case (m_state)
                        M_IDLE:
                            if (res == R_MULTI) m_state = M_BLOCK;
                            else if (res != R_NONE) begin
                                e_code = 4'(res); e_valid = 1'b1; m_state = M_HELD;
                            end
                        M_HELD:
                            if (res == R_NONE) m_state = M_IDLE;
                            else if (res != int'(e_code)) m_state = M_BLOCK;
                        default:
                            if (res == R_NONE) m_state = M_IDLE;
                    endcase
                end
                fmask = '0;
            end
        end
        m_s2 = m_s1; m_s1 = rin; t++;
    endtask

    task automatic tick();
        logic [3:0]  one;
        logic [10:0] exp;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        one = 4'b0001;
        exp = {~(one << ((t / SCAN_DIV) % 4)), e_code, e_valid,
               m_state == M_HELD, m_state == M_BLOCK};
        chk("outs", 32'({kif.col, kif.key_code, kif.key_valid, kif.key_down, kif.multi_key}),
            32'(exp));
        if (kif.key_valid) strobes++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align_frame();
        while (t % FRAME != 0) tick();
    endtask

    task automatic wait_strobe(output int lat);
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (kif.key_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int s0, lat;
        // Reset and plain column stepping
        rst = 1'b1;
        run(2);
        chk("rst_outs", 32'({kif.col, kif.key_code, kif.key_valid, kif.key_down, kif.multi_key}),
            32'(11'b1110_0000_000));
        rst = 1'b0;
        run(2 * FRAME);

        // Clean press of key 9 (row 2, col 1) held six frames
        align_frame();
        s0 = strobes;
        pressed[9] = 1'b1;
        wait_strobe(lat);
        chk("press_lat", 32'(lat), 32'(DEB_FRAMES * FRAME));
        chk("press_code", 32'(kif.key_code), 32'd9);
        run(6 * FRAME - lat);
        chk("press_down", 32'(kif.key_down), 32'd1);
        align_frame();
        pressed = '0;
        run(DEB_FRAMES * FRAME - 1);
        chk("rel_hold", 32'(kif.key_down), 32'd1);
        tick();
        chk("rel_fall", 32'(kif.key_down), 32'd0);
        chk("rel_code", 32'(kif.key_code), 32'd9);
        chk("press_count", 32'(strobes - s0), 32'd1);
        run(FRAME);

        // Bounce on key 5, then a firm hold
        align_frame();
        s0 = strobes;
        for (int i = 0; i < 4 * FRAME; i++) begin
            pressed[5] = ((i / 10) % 2 == 0);
            tick();
        end
        chk("bounce_quiet", 32'(strobes - s0), 32'd0);
        pressed[5] = 1'b1;
        run(5 * FRAME);
        chk("bounce_count", 32'(strobes - s0), 32'd1);
        chk("bounce_code", 32'(kif.key_code), 32'd5);
        pressed = '0;
        run(5 * FRAME);

        // Chord 0 + 15
        s0 = strobes;
        pressed[0] = 1'b1; pressed[15] = 1'b1;
        run(5 * FRAME);
        chk("chord_multi", 32'(kif.multi_key), 32'd1);
        chk("chord_down", 32'(kif.key_down), 32'd0);
        pressed[15] = 1'b0;
        run(5 * FRAME);
        chk("chord_part_multi", 32'(kif.multi_key), 32'd1);
        pressed = '0;
        run(5 * FRAME);
        chk("chord_clear", 32'({kif.multi_key, kif.key_down}), 32'd0);
        chk("chord_count", 32'(strobes - s0), 32'd0);

        // Rollover 3 -> 7
        s0 = strobes;
        pressed[3] = 1'b1;
        wait_strobe(lat);
        chk("roll_code3", 32'(kif.key_code), 32'd3);
        run(FRAME);
        pressed[7] = 1'b1;
        run(5 * FRAME);
        pressed[3] = 1'b0;
        run(5 * FRAME);
        chk("roll_count", 32'(strobes - s0), 32'd1);
        chk("roll_block", 32'(kif.multi_key), 32'd1);
        chk("roll_keep3", 32'(kif.key_code), 32'd3);
        pressed = '0;
        run(5 * FRAME);
        chk("roll_idle", 32'(kif.multi_key), 32'd0);
        pressed[7] = 1'b1;
        wait_strobe(lat);
        chk("roll_fresh", 32'(lat > 0), 32'd1);
        chk("roll_code7", 32'(kif.key_code), 32'd7);
        pressed = '0;
        run(5 * FRAME);

        // Reset while key 10 is held
        pressed[10] = 1'b1;
        run(5 * FRAME);
        chk("hold10_down", 32'(kif.key_down), 32'd1);
        rst = 1'b1;
        run(2);
        chk("rst_mid", 32'({kif.col, kif.key_code, kif.key_valid, kif.key_down, kif.multi_key}),
            32'(11'b1110_0000_000));
        rst = 1'b0;
        wait_strobe(lat);
        chk("rst_lat", 32'(lat), 32'(DEB_FRAMES * FRAME));
        chk("rst_code", 32'(kif.key_code), 32'd10);
        pressed = '0;
        run(5 * FRAME);

        // Random key activity: idle, single keys, chords, bounce, stray resets
        for (int n = 0; n < 40; n++) begin
            int kind, dur, per, k1, k2;
            kind = int'($urandom_range(0, 9));
            dur  = int'($urandom_range(8, 100));
            per  = int'($urandom_range(3, 12));
            k1   = int'($urandom_range(0, 15));
            k2   = int'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            pressed = '0;
            if (kind >= 2) pressed[k1] = 1'b1;
            if (kind == 8) pressed[k2] = 1'b1;
            for (int i = 0; i < dur; i++) begin
                if (kind == 9) pressed[k1] = ((i / per) % 2 == 0);
                tick();
            end
        end
        pressed = '0;
        run(5 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
